// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared widths and ALU function codes for the ID/EX stage.
package id_ex_stage_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_AW = 5;
    localparam int DEF_FUN_W  = 6;

    typedef enum logic [5:0] {
        ALU_ADD   = 6'b000000,
        ALU_SUB   = 6'b000001,
        ALU_AND   = 6'b011000,
        ALU_OR    = 6'b011110,
        ALU_XOR   = 6'b010110,
        ALU_NOR   = 6'b010001,
        ALU_PASSA = 6'b011010,
        ALU_SLL   = 6'b100000,
        ALU_SRL   = 6'b100001,
        ALU_SRA   = 6'b100011,
        ALU_EQ    = 6'b110011,
        ALU_NEQ   = 6'b110001,
        ALU_LT    = 6'b110101,
        ALU_LEZ   = 6'b111101,
        ALU_LTZ   = 6'b111011,
        ALU_GTZ   = 6'b111111
    } alu_fun_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// id_ex_stage_fwd_mux: picks one ALU source operand from EX/MEM, MEM/WB or the captured register-file value.
module id_ex_stage_fwd_mux #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src_addr,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              ex_mem_reg_write,
    input  logic              ex_mem_mem_to_reg,
    input  logic [REG_AW-1:0] ex_mem_waddr,
    input  logic [DATA_W-1:0] ex_mem_data,
    input  logic              mem_wb_reg_write,
    input  logic [REG_AW-1:0] mem_wb_waddr,
    input  logic [DATA_W-1:0] mem_wb_data,
    output logic [DATA_W-1:0] operand
);

    logic src_nz, hit_ex_mem, hit_mem_wb;

    // A load in EX/MEM has no result yet; the load-use stall keeps that case from arising.
    always_comb begin
        src_nz     = |src_addr;
        hit_ex_mem = src_nz && ex_mem_reg_write && !ex_mem_mem_to_reg && (ex_mem_waddr == src_addr);
        hit_mem_wb = src_nz && mem_wb_reg_write && (mem_wb_waddr == src_addr);
        operand    = hit_ex_mem ? ex_mem_data : hit_mem_wb ? mem_wb_data : rf_data;
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX operand forwarding and load-use detection.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW,
    parameter int FUN_W  = DEF_FUN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Hold,
    input  logic              Flush,
    input  logic              IdValid,
    input  logic [DATA_W-1:0] IdRsData,
    input  logic [DATA_W-1:0] IdRtData,
    input  logic [REG_AW-1:0] IdRsAddr,
    input  logic [REG_AW-1:0] IdRtAddr,
    input  logic              IdUsesRt,
    input  logic [4:0]        IdShamt,
    input  logic [15:0]       IdImm16,
    input  logic              IdExtOp,
    input  logic              IdLUOp,
    input  logic              IdALUSrc1,
    input  logic              IdALUSrc2,
    input  logic [FUN_W-1:0]  IdALUFun,
    input  logic              IdSign,
    input  logic [REG_AW-1:0] IdWAddr,
    input  logic              IdRegWrite,
    input  logic              IdMemRead,
    input  logic              IdMemWrite,
    input  logic              ExMemRegWrite,
    input  logic              ExMemMemToReg,
    input  logic [REG_AW-1:0] ExMemWAddr,
    input  logic [DATA_W-1:0] ExMemResult,
    input  logic              MemWbRegWrite,
    input  logic [REG_AW-1:0] MemWbWAddr,
    input  logic [DATA_W-1:0] MemWbWData,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [FUN_W-1:0]  ALUFun,
    output logic              Sign,
    output logic [DATA_W-1:0] StoreData,
    output logic [REG_AW-1:0] ExWAddr,
    output logic              ExRegWrite,
    output logic              ExMemRead,
    output logic              ExMemWrite,
    output logic              ExValid,
    output logic              LoadUse
);

    logic              valid_q, valid_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [REG_AW-1:0] waddr_q, waddr_d;
    logic [REG_AW-1:0] rs_addr_q, rs_addr_d;
    logic [REG_AW-1:0] rt_addr_q, rt_addr_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [4:0]        shamt_q, shamt_d;
    logic [DATA_W-1:0] ext_imm_q, ext_imm_d;
    logic              alu_src1_q, alu_src1_d;
    logic              alu_src2_q, alu_src2_d;
    logic [FUN_W-1:0]  alu_fun_q, alu_fun_d;
    logic              sign_q, sign_d;
    logic [DATA_W-1:0] id_ext_imm, fwd_rs, fwd_rt;

    always_comb begin
        id_ext_imm  = IdLUOp  ? DATA_W'({IdImm16, 16'h0000}) :
                      IdExtOp ? DATA_W'($signed(IdImm16)) : DATA_W'(IdImm16);
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        waddr_d     = waddr_q;
        rs_addr_d   = rs_addr_q;
        rt_addr_d   = rt_addr_q;
        rs_data_d   = rs_data_q;
        rt_data_d   = rt_data_q;
        shamt_d     = shamt_q;
        ext_imm_d   = ext_imm_q;
        alu_src1_d  = alu_src1_q;
        alu_src2_d  = alu_src2_q;
        alu_fun_d   = alu_fun_q;
        sign_d      = sign_q;
        // A bubble clears everything, so a flush overrides a concurrent hold.
        if (Flush) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            waddr_d     = '0;
            rs_addr_d   = '0;
            rt_addr_d   = '0;
            rs_data_d   = '0;
            rt_data_d   = '0;
            shamt_d     = '0;
            ext_imm_d   = '0;
            alu_src1_d  = 1'b0;
            alu_src2_d  = 1'b0;
            alu_fun_d   = FUN_W'(ALU_ADD);
            sign_d      = 1'b0;
        end else if (!Hold) begin
            valid_d     = IdValid;
            reg_write_d = IdRegWrite;
            mem_read_d  = IdMemRead;
            mem_write_d = IdMemWrite;
            waddr_d     = IdWAddr;
            rs_addr_d   = IdRsAddr;
            rt_addr_d   = IdRtAddr;
            rs_data_d   = IdRsData;
            rt_data_d   = IdRtData;
            shamt_d     = IdShamt;
            ext_imm_d   = id_ext_imm;
            alu_src1_d  = IdALUSrc1;
            alu_src2_d  = IdALUSrc2;
            alu_fun_d   = IdALUFun;
            sign_d      = IdSign;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            waddr_q     <= '0;
            rs_addr_q   <= '0;
            rt_addr_q   <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            shamt_q     <= '0;
            ext_imm_q   <= '0;
            alu_src1_q  <= 1'b0;
            alu_src2_q  <= 1'b0;
            alu_fun_q   <= FUN_W'(ALU_ADD);
            sign_q      <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            waddr_q     <= waddr_d;
            rs_addr_q   <= rs_addr_d;
            rt_addr_q   <= rt_addr_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            shamt_q     <= shamt_d;
            ext_imm_q   <= ext_imm_d;
            alu_src1_q  <= alu_src1_d;
            alu_src2_q  <= alu_src2_d;
            alu_fun_q   <= alu_fun_d;
            sign_q      <= sign_d;
        end
    end

    id_ex_stage_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .src_addr          (rs_addr_q),
        .rf_data           (rs_data_q),
        .ex_mem_reg_write  (ExMemRegWrite),
        .ex_mem_mem_to_reg (ExMemMemToReg),
        .ex_mem_waddr      (ExMemWAddr),
        .ex_mem_data       (ExMemResult),
        .mem_wb_reg_write  (MemWbRegWrite),
        .mem_wb_waddr      (MemWbWAddr),
        .mem_wb_data       (MemWbWData),
        .operand           (fwd_rs)
    );

    id_ex_stage_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .src_addr          (rt_addr_q),
        .rf_data           (rt_data_q),
        .ex_mem_reg_write  (ExMemRegWrite),
        .ex_mem_mem_to_reg (ExMemMemToReg),
        .ex_mem_waddr      (ExMemWAddr),
        .ex_mem_data       (ExMemResult),
        .mem_wb_reg_write  (MemWbRegWrite),
        .mem_wb_waddr      (MemWbWAddr),
        .mem_wb_data       (MemWbWData),
        .operand           (fwd_rt)
    );

    always_comb begin
        A          = alu_src1_q ? DATA_W'(shamt_q) : fwd_rs;
        B          = alu_src2_q ? ext_imm_q : fwd_rt;
        StoreData  = fwd_rt;
        ALUFun     = alu_fun_q;
        Sign       = sign_q;
        ExWAddr    = waddr_q;
        ExRegWrite = reg_write_q;
        ExMemRead  = mem_read_q;
        ExMemWrite = mem_write_q;
        ExValid    = valid_q;
        LoadUse    = valid_q && mem_read_q && (|waddr_q) &&
                     ((waddr_q == IdRsAddr) || (IdUsesRt && (waddr_q == IdRtAddr)));
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vectors for the ID/EX stage with hand-computed expectations.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        Hold, Flush, IdValid, IdUsesRt, IdExtOp, IdLUOp, IdALUSrc1, IdALUSrc2, IdSign;
    logic        IdRegWrite, IdMemRead, IdMemWrite;
    logic [31:0] IdRsData, IdRtData, ExMemResult, MemWbWData;
    logic [4:0]  IdRsAddr, IdRtAddr, IdShamt, IdWAddr, ExMemWAddr, MemWbWAddr;
    logic [15:0] IdImm16;
    logic [5:0]  IdALUFun;
    logic        ExMemRegWrite, ExMemMemToReg, MemWbRegWrite;
    logic [31:0] A, B, StoreData;
    logic [5:0]  ALUFun;
    logic        Sign, ExRegWrite, ExMemRead, ExMemWrite, ExValid, LoadUse;
    logic [4:0]  ExWAddr;

    int n_vec = 0;
    int n_err = 0;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .Hold(Hold), .Flush(Flush), .IdValid(IdValid),
        .IdRsData(IdRsData), .IdRtData(IdRtData), .IdRsAddr(IdRsAddr), .IdRtAddr(IdRtAddr),
        .IdUsesRt(IdUsesRt), .IdShamt(IdShamt), .IdImm16(IdImm16), .IdExtOp(IdExtOp),
        .IdLUOp(IdLUOp), .IdALUSrc1(IdALUSrc1), .IdALUSrc2(IdALUSrc2), .IdALUFun(IdALUFun),
        .IdSign(IdSign), .IdWAddr(IdWAddr), .IdRegWrite(IdRegWrite), .IdMemRead(IdMemRead),
        .IdMemWrite(IdMemWrite), .ExMemRegWrite(ExMemRegWrite), .ExMemMemToReg(ExMemMemToReg),
        .ExMemWAddr(ExMemWAddr), .ExMemResult(ExMemResult), .MemWbRegWrite(MemWbRegWrite),
        .MemWbWAddr(MemWbWAddr), .MemWbWData(MemWbWData), .A(A), .B(B), .ALUFun(ALUFun),
        .Sign(Sign), .StoreData(StoreData), .ExWAddr(ExWAddr), .ExRegWrite(ExRegWrite),
        .ExMemRead(ExMemRead), .ExMemWrite(ExMemWrite), .ExValid(ExValid), .LoadUse(LoadUse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic id_clear();
        IdValid = 0; IdRsData = 0; IdRtData = 0; IdRsAddr = 0; IdRtAddr = 0; IdUsesRt = 0;
        IdShamt = 0; IdImm16 = 0; IdExtOp = 0; IdLUOp = 0; IdALUSrc1 = 0; IdALUSrc2 = 0;
        IdALUFun = ALU_ADD; IdSign = 0; IdWAddr = 0; IdRegWrite = 0; IdMemRead = 0; IdMemWrite = 0;
    endtask

    task automatic byp_clear();
        ExMemRegWrite = 0; ExMemMemToReg = 0; ExMemWAddr = 0; ExMemResult = 0;
        MemWbRegWrite = 0; MemWbWAddr = 0; MemWbWData = 0;
    endtask

    task automatic rtype(input logic [4:0] rs, input logic [31:0] rsd, input logic [4:0] rt,
                         input logic [31:0] rtd, input logic [5:0] fun, input logic [4:0] wa);
        id_clear();
        IdValid = 1; IdRsAddr = rs; IdRsData = rsd; IdRtAddr = rt; IdRtData = rtd;
        IdUsesRt = 1; IdALUFun = fun; IdWAddr = wa; IdRegWrite = 1;
    endtask

    initial begin
        reset = 0; Hold = 0; Flush = 0;
        id_clear();
        byp_clear();
        step();
        step();
        chk("rst_A", A, 0);
        chk("rst_ALUFun", ALUFun, 32'(ALU_ADD));
        chk("rst_ExValid", ExValid, 0);
        reset = 1;

        // add $3,$1,$2
        rtype(5'd1, 32'h0F, 5'd2, 32'h0F, ALU_ADD, 5'd3);
        #1;
        chk("add_latency_ExValid", ExValid, 0);
        step();
        chk("add_A", A, 32'h0F);
        chk("add_B", B, 32'h0F);
        chk("add_ALUFun", ALUFun, 32'(ALU_ADD));
        chk("add_ExWAddr", ExWAddr, 3);
        chk("add_ExRegWrite", ExRegWrite, 1);
        chk("add_ExValid", ExValid, 1);

        // bypass priority
        ExMemRegWrite = 1; ExMemWAddr = 1; ExMemResult = 32'h11F0;
        MemWbRegWrite = 1; MemWbWAddr = 1; MemWbWData = 32'h5;
        Hold = 1;
        #1;
        chk("fwd_exmem_prio", A, 32'h11F0);
        chk("fwd_rt_untouched", B, 32'h0F);
        ExMemRegWrite = 0;
        #1;
        chk("fwd_memwb", A, 32'h5);
        ExMemRegWrite = 1; ExMemMemToReg = 1;
        #1;
        chk("fwd_exmem_load_skip", A, 32'h5);
        ExMemMemToReg = 0; ExMemWAddr = 2; MemWbWAddr = 2; MemWbWData = 32'h77;
        #1;
        chk("fwd_rt_B", B, 32'h11F0);
        chk("fwd_rt_store", StoreData, 32'h11F0);
        chk("fwd_rs_rf", A, 32'h0F);
        Hold = 0;
        byp_clear();
        rtype(5'd0, 32'h123, 5'd2, 32'h9, ALU_OR, 5'd4);
        step();
        ExMemRegWrite = 1; ExMemWAddr = 0; ExMemResult = 32'hDEAD;
        MemWbRegWrite = 1; MemWbWAddr = 0; MemWbWData = 32'hBEEF;
        #1;
        chk("fwd_zero_reg", A, 32'h123);
        byp_clear();

        // sll $5,$2,4
        rtype(5'd0, 32'h0, 5'd2, 32'hF0, ALU_SLL, 5'd5);
        IdALUSrc1 = 1; IdShamt = 5'd4;
        step();
        chk("sll_A", A, 32'h4);
        chk("sll_B", B, 32'hF0);
        chk("sll_ALUFun", ALUFun, 32'(ALU_SLL));
        // lui / sign / zero extension
        id_clear();
        IdValid = 1; IdALUSrc2 = 1; IdLUOp = 1; IdExtOp = 1; IdImm16 = 16'hF111; IdWAddr = 6; IdRegWrite = 1;
        step();
        chk("lui_B", B, 32'hF1110000);
        IdLUOp = 0; IdImm16 = 16'h8001; IdSign = 1;
        step();
        chk("sext_B", B, 32'hFFFF8001);
        chk("sext_Sign", Sign, 1);
        IdExtOp = 0;
        step();
        chk("zext_B", B, 32'h00008001);

        // lw $2,4($0) then a consumer of $2
        id_clear();
        IdValid = 1; IdALUSrc2 = 1; IdExtOp = 1; IdImm16 = 16'h4; IdWAddr = 2; IdRegWrite = 1; IdMemRead = 1;
        step();
        chk("lw_ExMemRead", ExMemRead, 1);
        rtype(5'd5, 32'h1, 5'd2, 32'h2, ALU_ADD, 5'd7);
        #1;
        chk("loaduse_rt", LoadUse, 1);
        IdUsesRt = 0;
        #1;
        chk("loaduse_rt_unused", LoadUse, 0);
        IdRsAddr = 5'd2;
        #1;
        chk("loaduse_rs", LoadUse, 1);
        Flush = 1;
        step();
        Flush = 0;
        chk("flush_ExValid", ExValid, 0);
        chk("flush_ExRegWrite", ExRegWrite, 0);
        chk("flush_ExMemRead", ExMemRead, 0);
        chk("flush_LoadUse", LoadUse, 0);
        chk("flush_B", B, 0);
        // load to $0 never stalls
        id_clear();
        IdValid = 1; IdMemRead = 1; IdWAddr = 0;
        step();
        IdRsAddr = 0; IdRtAddr = 0; IdUsesRt = 1;
        #1;
        chk("loaduse_zero_dst", LoadUse, 0);

        // hold vs flush
        rtype(5'd1, 32'h1234, 5'd2, 32'h5678, ALU_SUB, 5'd8);
        step();
        chk("sub_ALUFun", ALUFun, 32'(ALU_SUB));
        Hold = 1; Flush = 1;
        step();
        chk("holdflush_ExValid", ExValid, 0);
        chk("holdflush_A", A, 0);
        Flush = 0; Hold = 0;
        step();
        Hold = 1;
        for (int i = 0; i < 3; i++) begin
            rtype(5'd3, 32'hAAAA0000 + 32'(i), 5'd4, 32'h1, ALU_XOR, 5'd9);
            step();
            chk("hold_A", A, 32'h1234);
            chk("hold_ALUFun", ALUFun, 32'(ALU_SUB));
        end
        Hold = 0;
        step();
        chk("unhold_A", A, 32'hAAAA0002);
        chk("unhold_ALUFun", ALUFun, 32'(ALU_XOR));

        // async reset mid-cycle
        reset = 0;
        #1;
        chk("arst_A", A, 0);
        chk("arst_ExValid", ExValid, 0);
        chk("arst_LoadUse", LoadUse, 0);
        step();
        chk("arst_held_B", B, 0);
        #2;
        reset = 1;
        #1;
        chk("arst_release_no_capture", ExValid, 0);
        step();
        chk("arst_resume_A", A, 32'hAAAA0002);
        chk("arst_resume_ExValid", ExValid, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
